wb_pipe_reg: RTL and testbench

Parametrised MA→WB pipeline register. It carries the PC, instruction, ALU result, load result and control word from the memory-access stage to write-back, using a valid/ready handshake, a flush input, and an optional two-entry skid buffer. It replaces the fixed-width, always-enabled MA latch, so stalls and flushes propagate without losing or duplicating instructions.

---
 rtl/wb_pipe_reg.sv | 173 +++++++++++++++++
 tb/tb_wb_pipe_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MA->WB pipeline register with valid/ready handshake and flush.
// Optional feature macro: WB_PIPE_SKID_EN.
//   Defined: two-entry skid buffer with registered in_ready (occupancy 0..2).
//   Undefined: single output register with combinational in_ready (occupancy 0..1).
module wb_pipe_reg #(
    parameter int              XLEN     = 32,
    parameter int              CTRL_W   = 22,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_ld,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_ld,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_pc;
    logic [XLEN-1:0]   r_out_inst;
    logic [XLEN-1:0]   r_out_alu;
    logic [XLEN-1:0]   r_out_ld;
    logic [CTRL_W-1:0] r_out_ctrl;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_out_from_in;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

`ifdef WB_PIPE_SKID_EN
    logic [1:0]        r_occ;
    logic              r_in_ready;
    logic [XLEN-1:0]   r_skid_pc;
    logic [XLEN-1:0]   r_skid_inst;
    logic [XLEN-1:0]   r_skid_alu;
    logic [XLEN-1:0]   r_skid_ld;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_load_skid;
    logic              w_load_out_from_skid;

    // A new entry goes straight to the output register unless an older one stays there.
    assign w_load_out_from_in   = w_in_xfer && ((r_occ == S_EMPTY) || ((r_occ == S_ONE) && w_out_xfer));
    assign w_load_skid          = w_in_xfer && (r_occ == S_ONE) && !w_out_xfer;
    assign w_load_out_from_skid = (r_occ == S_TWO) && w_out_xfer;
    assign in_ready             = r_in_ready;
    assign occupancy            = r_occ;

    // Occupancy FSM; in_ready is registered as (next occupancy < 2) to cut the out_ready path.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ       <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_occ)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_occ       <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_occ      <= S_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        r_occ       <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        r_occ      <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_occ       <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Skid entry captures an accepted input that cannot move to the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_skid_alu  <= '0;
            r_skid_ld   <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_pc   <= in_pc;
            r_skid_inst <= in_inst;
            r_skid_alu  <= in_alu;
            r_skid_ld   <= in_ld;
            r_skid_ctrl <= in_ctrl;
        end
    end
`else
    // Without a skid slot the register may only accept when it is empty or draining.
    assign w_load_out_from_in = w_in_xfer;
    assign in_ready           = !r_out_valid || out_ready;
    assign occupancy          = {1'b0, r_out_valid};

    // Valid bit: set by an accepted entry, kept while WB stalls, cleared by reset/flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_in_xfer || (r_out_valid && !out_ready);
        end
    end
`endif

    // Output register payload: always the oldest entry, held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_pc   <= '0;
            r_out_inst <= NOP_INST;
            r_out_alu  <= '0;
            r_out_ld   <= '0;
            r_out_ctrl <= '0;
        end else if (flush) begin
            r_out_inst <= NOP_INST;
            r_out_ctrl <= '0;
        end else if (w_load_out_from_in) begin
            r_out_pc   <= in_pc;
            r_out_inst <= in_inst;
            r_out_alu  <= in_alu;
            r_out_ld   <= in_ld;
            r_out_ctrl <= in_ctrl;
`ifdef WB_PIPE_SKID_EN
        end else if (w_load_out_from_skid) begin
            r_out_pc   <= r_skid_pc;
            r_out_inst <= r_skid_inst;
            r_out_alu  <= r_skid_alu;
            r_out_ld   <= r_skid_ld;
            r_out_ctrl <= r_skid_ctrl;
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign out_alu   = r_out_alu;
    assign out_ld    = r_out_ld;
    assign out_ctrl  = r_out_valid ? r_out_ctrl : '0;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg (either build of WB_PIPE_SKID_EN).
module tb_wb_pipe_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [21:0] ctrl;
    } ent_t;

    typedef struct {
        logic iv;
        logic orr;
        logic fl;
        logic [31:0] pc;
        int   exp_occ;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_inst = '0, in_alu = '0, in_ld = '0;
    logic [21:0] in_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_alu, out_ld;
    logic [21:0] out_ctrl;
    logic [1:0]  occupancy;

    int   total = 0;
    int   bad = 0;
    int   m_occ = 0;
    int   delivered = 0;
    ent_t q[$];
    vec_t tbl[11];

    wb_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_alu(in_alu), .in_ld(in_ld), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_alu(out_alu), .out_ld(out_ld), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.inst = pc ^ 32'hA5A5_0000;
        e.alu  = pc * 32'd3 + 32'd7;
        e.ld   = ~pc;
        e.ctrl = pc[21:0] ^ 22'h15A5A5;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, advance the model at posedge.
    task automatic step(input logic iv, input logic orr, input logic fl, input logic [31:0] pc);
        ent_t e;
        logic m_ir, in_x, out_x;
        e = mk(pc);
        in_valid = iv; out_ready = orr; flush = fl;
        in_pc = e.pc; in_inst = e.inst; in_alu = e.alu; in_ld = e.ld; in_ctrl = e.ctrl;
        #1;
`ifdef WB_PIPE_SKID_EN
        m_ir = (m_occ < 2);
`else
        m_ir = (m_occ == 0) || orr;
`endif
        chk("in_ready", 32'(in_ready), 32'(m_ir));
        chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
        chk("occupancy", 32'(occupancy), m_occ);
        if (m_occ != 0) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_inst", out_inst, q[0].inst);
                chk("out_alu", out_alu, q[0].alu);
                chk("out_ld", out_ld, q[0].ld);
                chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
            end
        end else begin
            chk("out_ctrl_idle", 32'(out_ctrl), 32'd0);
        end
        in_x  = iv && m_ir;
        out_x = (m_occ != 0) && orr;
        @(posedge clk);
        if (out_x && q.size() > 0) begin
            void'(q.pop_front());
            delivered++;
        end
        if (fl) begin
            q.delete();
            m_occ = 0;
        end else begin
            if (in_x) q.push_back(e);
            m_occ = m_occ + int'(in_x) - int'(out_x);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // {in_valid, out_ready, flush, pc, occupancy after the edge}
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0014, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0018, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_001C, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0024, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0028, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_002C, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0030, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0034, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0038, 0};

        // Reset held two cycles with in_valid asserted
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_ctrl = 22'h3FFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        m_occ = 0;
        q.delete();

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].iv, tbl[i].orr, tbl[i].fl, tbl[i].pc);
            chk($sformatf("tbl_occ[%0d]", i), 32'(occupancy), tbl[i].exp_occ);
            chk($sformatf("tbl_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].exp_occ != 0));
        end

        // Streaming: 8 back-to-back entries, no bubbles
        d0 = delivered;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * k));
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stream_delivered", 32'(delivered - d0), 32'd8);

        // Backpressure: two offers while WB stalls, then drain
        step(1'b1, 1'b0, 1'b0, 32'h200);
        step(1'b1, 1'b0, 1'b0, 32'h204);
        chk("bp_hold_pc", out_pc, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_hold_pc2", out_pc, 32'h200);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Flush with a simultaneous input offer while full
        step(1'b1, 1'b0, 1'b0, 32'h280);
        step(1'b1, 1'b0, 1'b0, 32'h284);
        step(1'b1, 1'b0, 1'b1, 32'h300);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_inst", out_inst, 32'h0000_0013);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Flush with a simultaneous output transfer
        step(1'b1, 1'b0, 1'b0, 32'h400);
        d0 = delivered;
        step(1'b0, 1'b1, 1'b1, 32'h0);
        chk("flo_delivered", 32'(delivered - d0), 32'd1);
        chk("flo_valid", 32'(out_valid), 32'd0);
        chk("flo_ctrl", 32'(out_ctrl), 32'd0);

        // Stall with one entry, then replace with no bubble
        step(1'b1, 1'b0, 1'b0, 32'h500);
        step(1'b1, 1'b0, 1'b0, 32'h504);
        step(1'b1, 1'b1, 1'b0, 32'h508);
        step(1'b1, 1'b1, 1'b0, 32'h50C);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("final_occ", 32'(occupancy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
